// File: rtl/processing_system.sv
// Spike detection front end: byte-stream deserialiser feeding NUM_UNITS
// independent delta-metric detector/classifiers, each with a refractory timer.
module processing_system #(
  parameter int unsigned NUM_UNITS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               serial_data_in,
  input  logic [7:0]               class_a_thresh_in,
  input  logic [7:0]               class_b_thresh_in,
  input  logic [15:0]              timeout_period_in,
  output logic [NUM_UNITS-1:0]     spike_detection_array,
  output logic [2*NUM_UNITS-1:0]   event_out_array
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned FRAME_W  = NUM_UNITS * SAMPLE_W;
  localparam int unsigned BUF_W    = FRAME_W - BYTE_W;
  localparam int unsigned DIFF_W   = SAMPLE_W + 1;
  localparam int unsigned METRIC_W = 8;
  localparam int unsigned TIMER_W  = 16;
  localparam int unsigned CLASS_W  = 2;

  localparam logic [CLASS_W-1:0] CLASS_NONE = 2'b00;
  localparam logic [CLASS_W-1:0] CLASS_A    = 2'b01;
  localparam logic [CLASS_W-1:0] CLASS_B    = 2'b10;

  logic [2:0]           byte_cnt;
  logic [BUF_W-1:0]     byte_buf;
  logic [FRAME_W-1:0]   frame;
  logic                 frame_valid;

  logic [SAMPLE_W-1:0]  prev_sample [NUM_UNITS];
  logic [TIMER_W-1:0]   tcnt        [NUM_UNITS];

  logic [SAMPLE_W-1:0]  sample      [NUM_UNITS];
  logic [DIFF_W-1:0]    abs_diff    [NUM_UNITS];
  logic [METRIC_W-1:0]  metric      [NUM_UNITS];
  logic [CLASS_W-1:0]   cls         [NUM_UNITS];
  logic                 fire        [NUM_UNITS];

  // Bytes 0..6 shift in from the top; byte 7 completes the frame directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt    <= 3'd0;
      byte_buf    <= '0;
      frame       <= '0;
      frame_valid <= 1'b0;
    end else begin
      byte_cnt <= byte_cnt + 3'd1;
      byte_buf <= {serial_data_in, byte_buf[BUF_W-1:BYTE_W]};
      if (byte_cnt == 3'd7) begin
        frame       <= {serial_data_in, byte_buf};
        frame_valid <= 1'b1;
      end else begin
        frame_valid <= 1'b0;
      end
    end
  end

  // Per-unit metric, class (B has priority over A) and detection qualifier.
  always_comb begin
    for (int k = 0; k < int'(NUM_UNITS); k++) begin
      sample[k] = frame[SAMPLE_W*k +: SAMPLE_W];
      if (sample[k] >= prev_sample[k]) begin
        abs_diff[k] = DIFF_W'(sample[k]) - DIFF_W'(prev_sample[k]);
      end else begin
        abs_diff[k] = DIFF_W'(prev_sample[k]) - DIFF_W'(sample[k]);
      end
      metric[k] = (abs_diff[k] > DIFF_W'(255)) ? 8'hFF : abs_diff[k][METRIC_W-1:0];
      if (metric[k] >= class_b_thresh_in) begin
        cls[k] = CLASS_B;
      end else if (metric[k] >= class_a_thresh_in) begin
        cls[k] = CLASS_A;
      end else begin
        cls[k] = CLASS_NONE;
      end
      fire[k] = frame_valid && (cls[k] != CLASS_NONE) && (tcnt[k] == '0);
    end
  end

  // Detection loads the refractory timer; the event code clears once it has expired.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      spike_detection_array <= '0;
      event_out_array       <= '0;
      for (int k = 0; k < int'(NUM_UNITS); k++) begin
        prev_sample[k] <= '0;
        tcnt[k]        <= '0;
      end
    end else begin
      for (int k = 0; k < int'(NUM_UNITS); k++) begin
        if (frame_valid) begin
          prev_sample[k] <= sample[k];
        end
        if (fire[k]) begin
          spike_detection_array[k]            <= 1'b1;
          event_out_array[CLASS_W*k +: CLASS_W] <= cls[k];
          tcnt[k]                             <= timeout_period_in;
        end else begin
          spike_detection_array[k] <= 1'b0;
          if (tcnt[k] != '0) begin
            tcnt[k] <= tcnt[k] - TIMER_W'(1);
          end else begin
            event_out_array[CLASS_W*k +: CLASS_W] <= CLASS_NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_processing_system.sv
// Directed bench for processing_system: streams frames byte by byte and checks
// detection pulses, class codes, refractory timing and reset alignment.
module tb_processing_system;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  serial_data_in;
  logic [7:0]  class_a_thresh_in;
  logic [7:0]  class_b_thresh_in;
  logic [15:0] timeout_period_in;
  logic [3:0]  spike_detection_array;
  logic [7:0]  event_out_array;

  int          vectors = 0;
  int          miscompares = 0;
  logic [63:0] cur = '0;
  int          pos = 0;

  processing_system #(.NUM_UNITS(4)) dut (
    .clk                   (clk),
    .rst                   (rst),
    .serial_data_in        (serial_data_in),
    .class_a_thresh_in     (class_a_thresh_in),
    .class_b_thresh_in     (class_b_thresh_in),
    .timeout_period_in     (timeout_period_in),
    .spike_detection_array (spike_detection_array),
    .event_out_array       (event_out_array)
  );

  always #5 clk = ~clk;

  // Send the next byte of the current frame and settle just past the edge.
  task automatic tick();
    serial_data_in = cur[8*pos +: 8];
    @(posedge clk);
    #1;
    pos = (pos + 1) % 8;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic to_boundary();
    while (pos != 0) tick();
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst               = 1'b0;
    serial_data_in    = 8'h00;
    class_a_thresh_in = 8'd20;
    class_b_thresh_in = 8'd40;
    timeout_period_in = 16'd100;

    // Reset held with random bytes
    repeat (3) begin
      serial_data_in = 8'($urandom);
      @(posedge clk);
      #1;
    end
    chk("rst_spike", {4'b0, spike_detection_array}, 8'h00);
    chk("rst_event", event_out_array, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // First frame against zero history: all units saturate to class B
    cur = 64'h7766_5544_3322_1100;
    run(8);
    chk("lat_spike", {4'b0, spike_detection_array}, 8'h00);
    run(1);
    chk("t2_spike", {4'b0, spike_detection_array}, 8'h0F);
    chk("t2_event", event_out_array, 8'hAA);
    run(10);
    chk("t2_spike_10", {4'b0, spike_detection_array}, 8'h00);
    chk("t2_event_10", event_out_array, 8'hAA);

    // Large delta inside the refractory window, then clear at detection+101
    to_boundary();
    cur = 64'hFFFF_FFFF_FFFF_FFFF;
    run(8);
    run(1);
    chk("t4_blocked", {4'b0, spike_detection_array}, 8'h00);
    chk("t4_event", event_out_array, 8'hAA);
    run(76);
    chk("t4_hold_100", event_out_array, 8'hAA);
    run(1);
    chk("t4_clear_101", event_out_array, 8'h00);

    // Zero timeout, metric just below and exactly at class A threshold
    timeout_period_in = 16'd0;
    to_boundary();
    cur = 64'h1010_1010_1010_1010;
    run(8);
    run(1);
    chk("t3_f1_spike", {4'b0, spike_detection_array}, 8'h0F);
    run(1);
    chk("t3_f1_clear", event_out_array, 8'h00);
    to_boundary();
    cur = 64'h1010_1010_1010_101E;
    run(8);
    run(1);
    chk("t3_m14_spike", {4'b0, spike_detection_array}, 8'h00);
    chk("t3_m14_event", event_out_array, 8'h00);
    to_boundary();
    cur = 64'h1010_1010_1010_1032;
    run(8);
    run(1);
    chk("t3_m20_spike", {4'b0, spike_detection_array}, 8'h01);
    chk("t3_m20_event", event_out_array, 8'h01);
    run(1);
    chk("t3_m20_spike_off", {4'b0, spike_detection_array}, 8'h00);
    chk("t3_m20_event_off", event_out_array, 8'h00);

    // Zero thresholds: every frame fires class B
    class_a_thresh_in = 8'd0;
    class_b_thresh_in = 8'd0;
    to_boundary();
    run(1);
    chk("t5_a_spike", {4'b0, spike_detection_array}, 8'h0F);
    chk("t5_a_event", event_out_array, 8'hAA);
    run(1);
    chk("t5_a_spike_off", {4'b0, spike_detection_array}, 8'h00);
    chk("t5_a_event_off", event_out_array, 8'h00);
    to_boundary();
    run(1);
    chk("t5_b_spike", {4'b0, spike_detection_array}, 8'h0F);
    chk("t5_b_event", event_out_array, 8'hAA);

    // Mid-frame reset clears at once; the following frame aligns from byte 0
    to_boundary();
    timeout_period_in = 16'd100;
    run(1);
    chk("t6_pre_event", event_out_array, 8'hAA);
    run(2);
    rst = 1'b0;
    #1;
    chk("t6_rst_spike", {4'b0, spike_detection_array}, 8'h00);
    chk("t6_rst_event", event_out_array, 8'h00);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    pos = 0;
    class_a_thresh_in = 8'd20;
    class_b_thresh_in = 8'd40;
    timeout_period_in = 16'd0;
    cur = 64'h0100_0000_0030_0014;
    run(8);
    run(1);
    chk("t6_align_spike", {4'b0, spike_detection_array}, 8'h0B);
    chk("t6_align_event", event_out_array, 8'h89);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
